// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch for a 16-bit-word machine. After reset the
//             stage reads a 32-bit reset vector (high word, then low word)
//             from instruction memory. It then fetches one- and two-word
//             instructions. Bit 0 of an instruction word marks a two-word
//             instruction whose second word is an immediate. Fetched
//             instructions are presented on registered outputs for decode.
//  Ports    : i_clk             - clock, rising edge
//             i_reset           - asynchronous active-low reset
//             i_stall           - hold fetch state and outputs
//             i_branch_decision - redirect request (overrides stall)
//             i_pc_new          - redirect target
//             i_imem_data       - instruction memory read data (combinational)
//             o_imem_addr       - instruction memory word address
//             o_instruction     - registered instruction word
//             o_immediate       - registered immediate word (0 if one-word)
//             o_pc              - address of the first word of o_instruction
//             o_valid           - outputs hold a real instruction
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_VEC_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_decision,
    input  logic [31:0] i_pc_new,
    input  logic [15:0] i_imem_data,
    output logic [31:0] o_imem_addr,
    output logic [15:0] o_instruction,
    output logic [15:0] o_immediate,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    // Low vector word follows the high word, wrapping modulo 2^32.
    localparam logic [31:0] c_vec_lo_addr = RESET_VEC_ADDR + 32'd1;

    typedef enum logic [1:0] {
        VEC_HI = 2'd0,
        VEC_LO = 2'd1,
        FETCH  = 2'd2,
        IMM    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [15:0] r_pending;
    logic [31:0] r_pending_pc;
    logic [15:0] r_vec_hi;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [15:0] w_pending_nxt;
    logic [31:0] w_pending_pc_nxt;
    logic [15:0] w_vec_hi_nxt;
    logic [15:0] w_instruction_nxt;
    logic [15:0] w_immediate_nxt;
    logic [31:0] w_pc_out_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc + 32'd1;

    // Memory address: the two vector words during start-up, the PC afterwards.
    always_comb begin
        case (r_state)
            VEC_HI:  o_imem_addr = RESET_VEC_ADDR;
            VEC_LO:  o_imem_addr = c_vec_lo_addr;
            default: o_imem_addr = r_pc;
        endcase
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pending_nxt     = r_pending;
        w_pending_pc_nxt  = r_pending_pc;
        w_vec_hi_nxt      = r_vec_hi;
        w_instruction_nxt = o_instruction;
        w_immediate_nxt   = o_immediate;
        w_pc_out_nxt      = o_pc;
        w_valid_nxt       = o_valid;

        case (r_state)
            VEC_HI: begin
                w_vec_hi_nxt = i_imem_data;
                w_state_nxt  = VEC_LO;
            end
            VEC_LO: begin
                w_pc_nxt    = {r_vec_hi, i_imem_data};
                w_state_nxt = FETCH;
            end
            FETCH, IMM: begin
                if (i_branch_decision) begin
                    // Redirect wins over stall; any half-fetched
                    // two-word instruction is dropped.
                    w_pc_nxt         = i_pc_new;
                    w_valid_nxt      = 1'b0;
                    w_pending_nxt    = 16'h0000;
                    w_pending_pc_nxt = 32'h0000_0000;
                    w_state_nxt      = FETCH;
                end else if (!i_stall) begin
                    w_pc_nxt = w_pc_inc;
                    if (r_state == IMM) begin
                        w_instruction_nxt = r_pending;
                        w_immediate_nxt   = i_imem_data;
                        w_pc_out_nxt      = r_pending_pc;
                        w_valid_nxt       = 1'b1;
                        w_state_nxt       = FETCH;
                    end else if (i_imem_data[0]) begin
                        // First word of a two-word instruction: hold it
                        // and emit a bubble until the immediate arrives.
                        w_pending_nxt    = i_imem_data;
                        w_pending_pc_nxt = r_pc;
                        w_valid_nxt      = 1'b0;
                        w_state_nxt      = IMM;
                    end else begin
                        w_instruction_nxt = i_imem_data;
                        w_immediate_nxt   = 16'h0000;
                        w_pc_out_nxt      = r_pc;
                        w_valid_nxt       = 1'b1;
                    end
                end
            end
            default: w_state_nxt = VEC_HI;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= VEC_HI;
            r_pc          <= 32'h0000_0000;
            r_pending     <= 16'h0000;
            r_pending_pc  <= 32'h0000_0000;
            r_vec_hi      <= 16'h0000;
            o_instruction <= 16'h0000;
            o_immediate   <= 16'h0000;
            o_pc          <= 32'h0000_0000;
            o_valid       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pending     <= w_pending_nxt;
            r_pending_pc  <= w_pending_pc_nxt;
            r_vec_hi      <= w_vec_hi_nxt;
            o_instruction <= w_instruction_nxt;
            o_immediate   <= w_immediate_nxt;
            o_pc          <= w_pc_out_nxt;
            o_valid       <= w_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage. A 256-word
//             memory model (indexed by the low address byte) answers the
//             fetch address combinationally; each scenario task drives
//             stimulus and compares outputs against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_stall;
    logic        i_branch_decision;
    logic [31:0] i_pc_new;
    logic [15:0] i_imem_data;
    logic [31:0] o_imem_addr;
    logic [15:0] o_instruction;
    logic [15:0] o_immediate;
    logic [31:0] o_pc;
    logic        o_valid;

    logic [15:0] mem [0:255];

    int n_pass;
    int n_total;

    fetch_stage dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_stall           (i_stall),
        .i_branch_decision (i_branch_decision),
        .i_pc_new          (i_pc_new),
        .i_imem_data       (i_imem_data),
        .o_imem_addr       (o_imem_addr),
        .o_instruction     (o_instruction),
        .o_immediate       (o_immediate),
        .o_pc              (o_pc),
        .o_valid           (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_imem_data = mem[o_imem_addr[7:0]];

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_stall = 1'b0; i_branch_decision = 1'b0; i_pc_new = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[1]    = 16'h0010;
        mem[8'h10] = 16'h1A02;
        mem[8'h11] = 16'h2B04;
        tick(); tick();
        n_total++;
        if ({o_valid, o_instruction, o_immediate, o_pc} !== 65'h0)
            $display("FAIL reset_outputs: got v=%0b ins=%h imm=%h pc=%h, want all 0",
                     o_valid, o_instruction, o_immediate, o_pc);
        else n_pass++;
        n_total++;
        if (o_imem_addr !== 32'h0)
            $display("FAIL reset_addr: got %h want 00000000", o_imem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_vector();
        i_reset = 1'b1;          // released 1 time unit after an edge
        tick();                  // edge 1: vector high word read
        n_total++;
        if (o_imem_addr !== 32'h1 || o_valid !== 1'b0)
            $display("FAIL vec_lo_addr: got addr=%h v=%0b want addr=00000001 v=0", o_imem_addr, o_valid);
        else n_pass++;
        tick();                  // edge 2: PC loaded from vector
        n_total++;
        if (o_imem_addr !== 32'h10 || o_valid !== 1'b0)
            $display("FAIL vec_pc: got addr=%h v=%0b want addr=00000010 v=0", o_imem_addr, o_valid);
        else n_pass++;
    endtask

    task automatic test_one_word_and_stall();
        tick();                  // fetch 0x10
        n_total++;
        if ({o_valid, o_instruction, o_immediate, o_pc} !== {1'b1, 16'h1A02, 16'h0, 32'h10})
            $display("FAIL one_word_1: got v=%0b ins=%h imm=%h pc=%h want v=1 ins=1a02 imm=0000 pc=00000010",
                     o_valid, o_instruction, o_immediate, o_pc);
        else n_pass++;
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (o_imem_addr !== 32'h11 ||
                {o_valid, o_instruction, o_immediate, o_pc} !== {1'b1, 16'h1A02, 16'h0, 32'h10})
                $display("FAIL stall_hold_%0d: got addr=%h v=%0b ins=%h pc=%h want addr=00000011 v=1 ins=1a02 pc=00000010",
                         i, o_imem_addr, o_valid, o_instruction, o_pc);
            else n_pass++;
        end
        i_stall = 1'b0;
        tick();                  // fetch resumes at 0x11
        n_total++;
        if ({o_valid, o_instruction, o_immediate, o_pc} !== {1'b1, 16'h2B04, 16'h0, 32'h11})
            $display("FAIL one_word_2: got v=%0b ins=%h imm=%h pc=%h want v=1 ins=2b04 imm=0000 pc=00000011",
                     o_valid, o_instruction, o_immediate, o_pc);
        else n_pass++;
        n_total++;
        if (o_imem_addr !== 32'h12)
            $display("FAIL pc_after_stream: got %h want 00000012", o_imem_addr);
        else n_pass++;
    endtask

    task automatic test_two_word();
        // Redirect back to 0x10 and load a two-word instruction there.
        i_branch_decision = 1'b1; i_pc_new = 32'h10;
        tick();
        i_branch_decision = 1'b0;
        n_total++;
        if (o_valid !== 1'b0 || o_imem_addr !== 32'h10)
            $display("FAIL redirect_fetch: got v=%0b addr=%h want v=0 addr=00000010", o_valid, o_imem_addr);
        else n_pass++;
        mem[8'h10] = 16'h3C01;
        mem[8'h11] = 16'hBEEF;
        tick();                  // first word -> bubble
        n_total++;
        if (o_valid !== 1'b0 || o_imem_addr !== 32'h11)
            $display("FAIL two_word_bubble: got v=%0b addr=%h want v=0 addr=00000011", o_valid, o_imem_addr);
        else n_pass++;
        tick();                  // immediate word
        n_total++;
        if ({o_valid, o_instruction, o_immediate, o_pc} !== {1'b1, 16'h3C01, 16'hBEEF, 32'h10})
            $display("FAIL two_word_out: got v=%0b ins=%h imm=%h pc=%h want v=1 ins=3c01 imm=beef pc=00000010",
                     o_valid, o_instruction, o_immediate, o_pc);
        else n_pass++;
        n_total++;
        if (o_imem_addr !== 32'h12)
            $display("FAIL two_word_next: got %h want 00000012", o_imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_in_imm();
        mem[8'h12] = 16'h5501;
        mem[8'h13] = 16'h1111;
        mem[8'h40] = 16'h7700;
        tick();                  // enter IMM holding 0x5501
        i_stall = 1'b1; i_branch_decision = 1'b1; i_pc_new = 32'h40;
        tick();
        i_stall = 1'b0; i_branch_decision = 1'b0;
        n_total++;
        if (o_valid !== 1'b0 || o_imem_addr !== 32'h40)
            $display("FAIL redirect_imm: got v=%0b addr=%h want v=0 addr=00000040", o_valid, o_imem_addr);
        else n_pass++;
        tick();                  // pending dropped: plain one-word at 0x40
        n_total++;
        if ({o_valid, o_instruction, o_immediate, o_pc} !== {1'b1, 16'h7700, 16'h0, 32'h40})
            $display("FAIL redirect_target: got v=%0b ins=%h imm=%h pc=%h want v=1 ins=7700 imm=0000 pc=00000040",
                     o_valid, o_instruction, o_immediate, o_pc);
        else n_pass++;
    endtask

    task automatic test_reset_and_wrap();
        mem[8'h41] = 16'h9901;
        mem[8'h42] = 16'h2222;
        mem[1]     = 16'h0050;
        mem[8'h50] = 16'h0000;
        mem[8'hFF] = 16'h1234;
        tick();                  // now in IMM
        i_reset = 1'b0;
        #1;
        n_total++;
        if ({o_valid, o_instruction, o_immediate, o_pc} !== 65'h0 || o_imem_addr !== 32'h0)
            $display("FAIL async_reset: got v=%0b ins=%h imm=%h pc=%h addr=%h want all 0",
                     o_valid, o_instruction, o_immediate, o_pc, o_imem_addr);
        else n_pass++;
        tick();
        i_reset = 1'b1;
        // Stall and redirect must be ignored while the vector is read.
        i_stall = 1'b1; i_branch_decision = 1'b1; i_pc_new = 32'h99;
        tick();
        n_total++;
        if (o_imem_addr !== 32'h1)
            $display("FAIL vec_ignore_ctrl_1: got %h want 00000001", o_imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if (o_imem_addr !== 32'h50 || o_valid !== 1'b0)
            $display("FAIL vec_ignore_ctrl_2: got addr=%h v=%0b want addr=00000050 v=0", o_imem_addr, o_valid);
        else n_pass++;
        i_stall = 1'b0; i_pc_new = 32'hFFFF_FFFF;
        tick();                  // redirect to top of address space
        i_branch_decision = 1'b0;
        n_total++;
        if (o_imem_addr !== 32'hFFFF_FFFF)
            $display("FAIL wrap_redirect: got %h want ffffffff", o_imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h1234, 32'hFFFF_FFFF} || o_imem_addr !== 32'h0)
            $display("FAIL pc_wrap: got v=%0b ins=%h pc=%h addr=%h want v=1 ins=1234 pc=ffffffff addr=00000000",
                     o_valid, o_instruction, o_pc, o_imem_addr);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_reset_vector();
        test_one_word_and_stall();
        test_two_word();
        test_redirect_in_imm();
        test_reset_and_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
